compare_arbiter: RTL

COMPARE_ARBITER -- requirements
Module: compare_arbiter

---
 rtl/cmp_pkg.sv | 19 +
 rtl/compare_core.sv | 70 +++++++
 rtl/compare_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and defaults for the compare_arbiter slice.
package cmp_pkg;

   localparam int CMP_WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      OP_EQ  = 2'b00,
      OP_LT  = 2'b01,
      OP_LTU = 2'b10,
      OP_RSV = 2'b11
   } cmp_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } cmp_state_e;

endpackage

// File: rtl/compare_core.sv
// Combinational comparator: EQ, signed LT and, with CMP_LTU_EN defined, unsigned LT.
module compare_core
   import cmp_pkg::*;
#(
   parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             result,
   output logic             err
);

   logic [WIDTH-1:0] diff_s;
   logic             eq_s;
   logic             lt_s;

`ifdef CMP_LTU_EN
   logic [WIDTH:0] sum_s;
   logic           ltu_s;

   // One adder provides both the difference and the borrow for LTU.
   assign sum_s  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign diff_s = sum_s[WIDTH-1:0];
   assign ltu_s  = ~sum_s[WIDTH];
`else
   assign diff_s = a - b;
`endif

   assign eq_s = (diff_s == {WIDTH{1'b0}});
   // Sign-aware form stays correct when a - b overflows.
   assign lt_s = (a[WIDTH-1] & ~b[WIDTH-1]) |
                 (~(a[WIDTH-1] ^ b[WIDTH-1]) & diff_s[WIDTH-1]);

   // Operation select; unsupported encodings report an error with result 0.
   always_comb begin
      result = 1'b0;
      err    = 1'b0;
      case (cmp_op_e'(op))
         OP_EQ: begin
            result = eq_s;
            err    = 1'b0;
         end
         OP_LT: begin
            result = lt_s;
            err    = 1'b0;
         end
`ifdef CMP_LTU_EN
         OP_LTU: begin
            result = ltu_s;
            err    = 1'b0;
         end
`else
         OP_LTU: begin
            result = 1'b0;
            err    = 1'b1;
         end
`endif
         OP_RSV: begin
            result = 1'b0;
            err    = 1'b1;
         end
         default: begin
            result = 1'b0;
            err    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin front end for two requesters sharing one compare_core, one operation in flight.
// Build option: define CMP_LTU_EN to enable unsigned less-than (op 10).
module compare_arbiter
   import cmp_pkg::*;
#(
   parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic             rsp_result,
   output logic             rsp_err
);

   cmp_state_e       state_q, state_d;
   logic             ptr_q, ptr_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             id_q, id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic             rsp_result_q, rsp_result_d;
   logic             rsp_err_q, rsp_err_d;

   logic             idle_s;
   logic             any_valid_s;
   logic             gnt_id_s;
   logic             core_result_s;
   logic             core_err_s;

   assign idle_s      = (state_q == ST_IDLE);
   assign any_valid_s = req0_valid | req1_valid;
   // The pointer only matters on contention; a lone requester wins outright.
   assign gnt_id_s    = (req0_valid & req1_valid) ? ptr_q : req1_valid;

   assign req0_ready = rst_n & idle_s & req0_valid & ~gnt_id_s;
   assign req1_ready = rst_n & idle_s & req1_valid &  gnt_id_s;

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_err    = rsp_err_q;

   compare_core #(.WIDTH(WIDTH)) u_core (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (core_result_s),
      .err    (core_err_s)
   );

   // Next-state: grant and latch in IDLE, capture result in EXEC, hold until consumed in DONE.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (any_valid_s) begin
               state_d = ST_EXEC;
               ptr_d   = ~gnt_id_s;
               id_d    = gnt_id_s;
               op_d    = gnt_id_s ? req1_op : req0_op;
               a_d     = gnt_id_s ? req1_a  : req0_a;
               b_d     = gnt_id_s ? req1_b  : req0_b;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            rsp_result_d = core_result_s;
            rsp_err_d    = core_err_s;
            rsp_id_d     = id_q;
            rsp_valid_d  = 1'b1;
            state_d      = ST_DONE;
         end
         ST_DONE: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               rsp_valid_d = 1'b1;
               state_d     = ST_DONE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and response registers; reset drops any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= 1'b0;
         op_q         <= 2'b00;
         a_q          <= {WIDTH{1'b0}};
         b_q          <= {WIDTH{1'b0}};
         id_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

endmodule
